// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared types and constants for the MEM stage and MEM/WB
//               register of the 64-bit 5-stage CPU.
//               - state_t     : access FSM states (IDLE / ACCESS)
//               - wb_bundle_t : write-back bundle held by the MEM/WB register
//               - WB_SRC_*    : encodings of the mem_to_reg select
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  // Legacy-compatible state encodings; the enum below is built on them.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  typedef enum logic [0:0] {
    IDLE   = ST_IDLE,
    ACCESS = ST_ACCESS
  } state_t;

  // Write-back source select. 10/11 are reserved and behave like ALU.
  localparam logic [1:0] WB_SRC_ALU = 2'b00;
  localparam logic [1:0] WB_SRC_MEM = 2'b01;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        choose_rd;
  } wb_bundle_t;

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage_if
// Description : Request/acknowledge bus between the MEM stage and the
//               variable-latency data memory.
//               mem_req   stage->mem  request, held for the whole access
//               mem_we    stage->mem  1 = write
//               mem_addr  stage->mem  64-bit byte address (8-byte aligned)
//               mem_wdata stage->mem  store data
//               mem_rdata mem->stage  read data, valid with mem_ack
//               mem_ack   mem->stage  one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_wb_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface : mem_wb_stage_if
`default_nettype wire

// File: rtl/mem_wb_reg.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_reg
// Description : MEM/WB pipeline register with load enable and bubble insert.
//               clk    in   clock, rising edge
//               reset  in   asynchronous clear, active-low
//               en     in   load d on this edge
//               bubble in   when loading, force valid and reg_write to 0
//               d      in   incoming write-back bundle
//               q      out  registered write-back bundle
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       en,
  input  wire logic       bubble,
  input  wire wb_bundle_t d,
  output wb_bundle_t      q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
      // A bubble still carries rd/choose_rd/data, but can never commit.
      if (bubble) begin
        q.valid     <= 1'b0;
        q.reg_write <= 1'b0;
      end
    end
  end

endmodule : mem_wb_reg
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : Memory stage plus MEM/WB register. Issues loads/stores over a
//               req/ack bus, stalls upstream while an access is outstanding,
//               aborts after TIMEOUT_CYCLES without ack, and registers the
//               write-back bundle.
//               clk, reset(active-low, async)
//               in_valid, alu_result, write_data, rd, mem_to_reg, reg_write,
//               mem_write, read_enable, choose_rd   : EX/MEM register outputs
//               stall                               : combinational hold
//               mem (mem_wb_stage_if.master)        : data-memory bus
//               wb_valid, wb_reg_write, wb_rd, wb_data, wb_choose_rd
//               err_misalign, err_timeout           : one-cycle error pulses
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        in_valid,
  input  wire logic [63:0] alu_result,
  input  wire logic [63:0] write_data,
  input  wire logic [4:0]  rd,
  input  wire logic [1:0]  mem_to_reg,
  input  wire logic        reg_write,
  input  wire logic        mem_write,
  input  wire logic        read_enable,
  input  wire logic        choose_rd,
  output logic             stall,
  mem_wb_stage_if.master   mem,
  output logic             wb_valid,
  output logic             wb_reg_write,
  output logic [4:0]       wb_rd,
  output logic [63:0]      wb_data,
  output logic             wb_choose_rd,
  output logic             err_misalign,
  output logic             err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [63:0]      r_mem_addr;
  logic [63:0]      r_mem_wdata;
  logic             r_err_misalign;
  logic             r_err_timeout;

  logic       w_mem_op;
  logic       w_misalign;
  logic       w_in_idle;
  logic       w_in_access;
  logic       w_ack;
  logic       w_timeout_hit;
  logic       w_wb_en;
  logic       w_wb_bubble;
  logic       w_sel_rdata;
  wb_bundle_t w_wb_d;
  wb_bundle_t w_wb_q;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  assign w_mem_op    = in_valid & (mem_write | read_enable);
  assign w_misalign  = (alu_result[2:0] != 3'b000);
  assign w_in_idle   = (r_state == IDLE);
  assign w_in_access = (r_state == ACCESS);

  // Ack only counts while an access is outstanding.
  assign w_ack         = w_in_access & mem.mem_ack;
  // Ack in the final cycle takes precedence over the abort.
  assign w_timeout_hit = w_in_access & ~mem.mem_ack & (r_cnt == CNT_LAST);

  // Hold upstream while starting an access and until it either completes or
  // aborts; on abort the instruction is dropped so upstream may move on.
  always_comb begin
    stall = 1'b0;
    if (w_in_idle) begin
      stall = w_mem_op & ~w_misalign;
    end else begin
      stall = ~(w_ack | w_timeout_hit);
    end
  end

  // --------------------------------------------------------------------------
  // MEM/WB register control and write-back mux
  // --------------------------------------------------------------------------
  // In IDLE every memory op leaves a bubble behind: either it faulted or it
  // is only now entering ACCESS. In ACCESS the slot waits for ack/abort.
  assign w_wb_en     = w_in_idle | w_ack | w_timeout_hit;
  assign w_wb_bubble = w_in_idle ? w_mem_op : w_timeout_hit;

  // Stores win over loads, so a store never selects read data.
  assign w_sel_rdata = w_ack & read_enable & ~mem_write & (mem_to_reg == WB_SRC_MEM);

  always_comb begin
    w_wb_d           = '0;
    w_wb_d.valid     = in_valid;
    w_wb_d.reg_write = reg_write & in_valid;
    w_wb_d.rd        = rd;
    w_wb_d.data      = w_sel_rdata ? mem.mem_rdata : alu_result;
    w_wb_d.choose_rd = choose_rd;
  end

  mem_wb_reg u_mem_wb_reg (
    .clk    (clk),
    .reset  (reset),
    .en     (w_wb_en),
    .bubble (w_wb_bubble),
    .d      (w_wb_d),
    .q      (w_wb_q)
  );

  assign wb_valid     = w_wb_q.valid;
  assign wb_reg_write = w_wb_q.reg_write;
  assign wb_rd        = w_wb_q.rd;
  assign wb_data      = w_wb_q.data;
  assign wb_choose_rd = w_wb_q.choose_rd;

  // --------------------------------------------------------------------------
  // Access FSM and memory request registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_err_misalign <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      r_err_misalign <= w_in_idle & w_mem_op & w_misalign;
      r_err_timeout  <= w_timeout_hit;
      case (r_state)
        IDLE: begin
          if (w_mem_op && !w_misalign) begin
            r_state     <= ACCESS;
            r_mem_req   <= 1'b1;
            r_mem_we    <= mem_write;
            r_mem_addr  <= alu_result;
            r_mem_wdata <= write_data;
            r_cnt       <= '0;
          end
        end
        ACCESS: begin
          if (w_ack || w_timeout_hit) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;
  assign err_misalign  = r_err_misalign;
  assign err_timeout   = r_err_timeout;

endmodule : mem_wb_stage
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Directed self-checking bench for mem_wb_stage
//               (TIMEOUT_CYCLES = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [63:0] alu_result;
  logic [63:0] write_data;
  logic [4:0]  rd;
  logic [1:0]  mem_to_reg;
  logic        reg_write;
  logic        mem_write;
  logic        read_enable;
  logic        choose_rd;
  logic        stall;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        wb_choose_rd;
  logic        err_misalign;
  logic        err_timeout;

  int checks;
  int failures;

  mem_wb_stage_if mem ();

  mem_wb_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .alu_result   (alu_result),
    .write_data   (write_data),
    .rd           (rd),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .mem_write    (mem_write),
    .read_enable  (read_enable),
    .choose_rd    (choose_rd),
    .stall        (stall),
    .mem          (mem.master),
    .wb_valid     (wb_valid),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_choose_rd (wb_choose_rd),
    .err_misalign (err_misalign),
    .err_timeout  (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_bubble();
    in_valid    = 1'b0;
    alu_result  = 64'h0;
    write_data  = 64'h0;
    rd          = 5'd0;
    mem_to_reg  = 2'b00;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    read_enable = 1'b0;
    choose_rd   = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
    checks++; if (wb_data !== 64'h0) begin failures++; $display("FAIL reset_wb_data got=%h exp=0", wb_data); end
    checks++; if (mem.mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem.mem_req); end
    checks++; if ({err_misalign, err_timeout} !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", {err_misalign, err_timeout}); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
  endtask

  task automatic test_alu();
    @(negedge clk);
    drive_bubble();
    in_valid = 1'b1; alu_result = 64'h1234; rd = 5'd5; reg_write = 1'b1; choose_rd = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b exp=0", stall); end
    @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL alu_wb_valid got=%b exp=1", wb_valid); end
    checks++; if (wb_data !== 64'h1234) begin failures++; $display("FAIL alu_wb_data got=%h exp=1234", wb_data); end
    checks++; if (wb_rd !== 5'd5) begin failures++; $display("FAIL alu_wb_rd got=%0d exp=5", wb_rd); end
    checks++; if (wb_reg_write !== 1'b1) begin failures++; $display("FAIL alu_wb_reg_write got=%b exp=1", wb_reg_write); end
    checks++; if (wb_choose_rd !== 1'b1) begin failures++; $display("FAIL alu_wb_choose_rd got=%b exp=1", wb_choose_rd); end
    // Reserved select and a stray ack in IDLE: both must be ignored.
    @(negedge clk);
    alu_result = 64'hABCD; mem_to_reg = 2'b10; choose_rd = 1'b0;
    mem.mem_ack = 1'b1; mem.mem_rdata = 64'hFFFF;
    @(posedge clk); #1;
    mem.mem_ack = 1'b0;
    checks++; if (wb_data !== 64'hABCD) begin failures++; $display("FAIL alu_reserved_sel got=%h exp=abcd", wb_data); end
    checks++; if (mem.mem_req !== 1'b0) begin failures++; $display("FAIL alu_stray_ack_req got=%b exp=0", mem.mem_req); end
    checks++; if (wb_choose_rd !== 1'b0) begin failures++; $display("FAIL alu_choose_rd_0 got=%b exp=0", wb_choose_rd); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive_bubble();
    in_valid = 1'b1; alu_result = 64'h11; rd = 5'd1; reg_write = 1'b1;
    @(posedge clk); #1;
    checks++; if (wb_data !== 64'h11) begin failures++; $display("FAIL b2b_first got=%h exp=11", wb_data); end
    @(negedge clk);
    alu_result = 64'h22; rd = 5'd2; reg_write = 1'b0;
    @(posedge clk); #1;
    checks++; if ({wb_data, wb_rd, wb_reg_write} !== {64'h22, 5'd2, 1'b0}) begin failures++; $display("FAIL b2b_second got=%h/%0d/%b exp=22/2/0", wb_data, wb_rd, wb_reg_write); end
  endtask

  task automatic test_load();
    int  nreq;
    int  nstall;
    bit  done;
    nreq = 0; nstall = 0; done = 0;
    @(negedge clk);
    drive_bubble();
    in_valid = 1'b1; alu_result = 64'h100; rd = 5'd7; mem_to_reg = 2'b01;
    reg_write = 1'b1; read_enable = 1'b1;
    for (int c = 0; c < 12 && !done; c++) begin
      if (mem.mem_req) nreq++;
      mem.mem_ack   = mem.mem_req && (nreq == 4);
      mem.mem_rdata = mem.mem_ack ? 64'hDEAD : 64'h0;
      #1;
      if (stall) nstall++;
      if (mem.mem_req && nreq == 1) begin
        checks++; if ({mem.mem_addr, mem.mem_we} !== {64'h100, 1'b0}) begin failures++; $display("FAIL load_bus got=%h/%b exp=100/0", mem.mem_addr, mem.mem_we); end
      end
      @(posedge clk); #1;
      mem.mem_ack = 1'b0;
      if (wb_valid) done = 1;
      @(negedge clk);
    end
    drive_bubble();
    checks++; if (!done) begin failures++; $display("FAIL load_complete got=timeout exp=wb_valid"); end
    checks++; if (nstall !== 4) begin failures++; $display("FAIL load_stall_cycles got=%0d exp=4", nstall); end
    checks++; if (wb_data !== 64'hDEAD) begin failures++; $display("FAIL load_wb_data got=%h exp=dead", wb_data); end
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL load_ack_last_no_timeout got=%b exp=0", err_timeout); end
  endtask

  task automatic test_store();
    @(negedge clk);
    drive_bubble();
    in_valid = 1'b1; alu_result = 64'h108; write_data = 64'hBEEF; rd = 5'd3;
    mem_to_reg = 2'b01; mem_write = 1'b1; read_enable = 1'b1; reg_write = 1'b0;
    @(posedge clk); #1;
    checks++; if ({mem.mem_req, mem.mem_we} !== 2'b11) begin failures++; $display("FAIL store_req_we got=%b exp=11", {mem.mem_req, mem.mem_we}); end
    checks++; if (mem.mem_addr !== 64'h108) begin failures++; $display("FAIL store_addr got=%h exp=108", mem.mem_addr); end
    checks++; if (mem.mem_wdata !== 64'hBEEF) begin failures++; $display("FAIL store_wdata got=%h exp=beef", mem.mem_wdata); end
    @(negedge clk);
    mem.mem_ack = 1'b1; mem.mem_rdata = 64'h7777;
    @(posedge clk); #1;
    mem.mem_ack = 1'b0;
    checks++; if ({wb_valid, wb_reg_write} !== 2'b10) begin failures++; $display("FAIL store_wb_flags got=%b exp=10", {wb_valid, wb_reg_write}); end
    checks++; if (wb_data !== 64'h108) begin failures++; $display("FAIL store_wb_data got=%h exp=108", wb_data); end
    @(negedge clk);
    drive_bubble();
  endtask

  task automatic test_misalign();
    @(negedge clk);
    drive_bubble();
    in_valid = 1'b1; alu_result = 64'h103; read_enable = 1'b1; mem_to_reg = 2'b01; reg_write = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL misalign_stall got=%b exp=0", stall); end
    @(posedge clk); #1;
    checks++; if (err_misalign !== 1'b1) begin failures++; $display("FAIL misalign_pulse got=%b exp=1", err_misalign); end
    checks++; if ({mem.mem_req, wb_valid, wb_reg_write} !== 3'b000) begin failures++; $display("FAIL misalign_req_wb got=%b exp=000", {mem.mem_req, wb_valid, wb_reg_write}); end
    @(negedge clk);
    drive_bubble();
    @(posedge clk); #1;
    checks++; if (err_misalign !== 1'b0) begin failures++; $display("FAIL misalign_one_cycle got=%b exp=0", err_misalign); end
  endtask

  task automatic test_timeout();
    int nreq;
    bit seen;
    nreq = 0; seen = 0;
    @(negedge clk);
    drive_bubble();
    in_valid = 1'b1; alu_result = 64'h200; read_enable = 1'b1; mem_to_reg = 2'b01; reg_write = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (mem.mem_req) nreq++;
      @(posedge clk); #1;
      if (err_timeout) seen = 1;
      @(negedge clk);
    end
    checks++; if (!seen) begin failures++; $display("FAIL timeout_pulse got=none exp=err_timeout"); end
    checks++; if (nreq !== 4) begin failures++; $display("FAIL timeout_req_cycles got=%0d exp=4", nreq); end
    checks++; if ({mem.mem_req, wb_valid} !== 2'b00) begin failures++; $display("FAIL timeout_req_wb got=%b exp=00", {mem.mem_req, wb_valid}); end
    drive_bubble();
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL timeout_stall got=%b exp=0", stall); end
    @(posedge clk); #1;
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL timeout_one_cycle got=%b exp=0", err_timeout); end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    drive_bubble();
    in_valid = 1'b1; alu_result = 64'h300; rd = 5'd9; read_enable = 1'b1; reg_write = 1'b1; choose_rd = 1'b1;
    @(posedge clk); #1;
    checks++; if ({mem.mem_req, wb_rd} !== {1'b1, 5'd9}) begin failures++; $display("FAIL rst_pre_state got=%b/%0d exp=1/9", mem.mem_req, wb_rd); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (mem.mem_req !== 1'b0) begin failures++; $display("FAIL rst_mid_req got=%b exp=0", mem.mem_req); end
    checks++; if ({wb_valid, wb_reg_write, wb_rd, wb_data, wb_choose_rd} !== '0) begin failures++; $display("FAIL rst_mid_wb got=%b/%b/%0d/%h/%b exp=all0", wb_valid, wb_reg_write, wb_rd, wb_data, wb_choose_rd); end
    @(negedge clk);
    reset = 1'b1;
    drive_bubble();
    in_valid = 1'b1; alu_result = 64'h5555; rd = 5'd3; reg_write = 1'b1;
    @(posedge clk); #1;
    checks++; if ({wb_valid, wb_data, wb_rd} !== {1'b1, 64'h5555, 5'd3}) begin failures++; $display("FAIL rst_after_alu got=%b/%h/%0d exp=1/5555/3", wb_valid, wb_data, wb_rd); end
    checks++; if (mem.mem_req !== 1'b0) begin failures++; $display("FAIL rst_after_req got=%b exp=0", mem.mem_req); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = 64'h0;
    drive_bubble();
    repeat (2) @(negedge clk);
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    test_alu();
    test_back_to_back();
    test_load();
    test_store();
    test_misalign();
    test_timeout();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_wb_stage
`default_nettype wire
